// File: rtl/cpu_mem_responder.sv
// -----------------------------------------------------------------------------
// cpu_mem_responder
//   Memory-side responder for the 19-bit CPU's load/store traffic. Accepts one
//   request at a time, waits a fixed access latency and then returns read data
//   or a write completion. Addresses at or above DEPTH are flagged with rsp_err.
//   Out-of-range writes are dropped, and out-of-range reads return zero.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : asynchronous, active-high reset (array contents are retained)
//   req_valid  : request present             req_ready : responder is idle
//   req_we     : 1 = write, 0 = read         req_addr  : word address
//   req_wdata  : write data
//   rsp_valid  : response present            rsp_ready : CPU takes the response
//   rsp_rdata  : read data (0 for writes and errors)
//   rsp_err    : request address was >= DEPTH
// -----------------------------------------------------------------------------
module cpu_mem_responder #(
    parameter int DATA_W  = 19,
    parameter int ADDR_W  = 19,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0]  LAT_M1  = CNT_W'(LATENCY - 1);
    // One extra bit so that DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              req_err;
    logic              mem_we;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_word;

    assign accept  = req_valid && req_ready;
    assign req_err = {1'b0, req_addr} >= DEPTH_C;
    assign req_idx = req_addr[IDX_W-1:0];

    // With LATENCY == 1 the read is captured on the acceptance edge itself, so
    // the live request index is used while idle; otherwise the latched one.
    assign rd_idx  = (state_q == IDLE) ? req_idx : idx_q;
    assign rd_word = mem[rd_idx];

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage array.
    // NOTE: the array deliberately has no reset; contents survive reset and
    // a resettable array would not map onto RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[req_idx] <= req_wdata;
        end
    end

    // Next-state and datapath logic.
    // NOTE: every signal gets a default at the top so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        err_d   = err_q;
        idx_d   = idx_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d   = req_we;
                    err_d  = req_err;
                    idx_d  = req_idx;
                    // Writes commit on the acceptance edge; out-of-range ones vanish.
                    mem_we = req_we && !req_err;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        rdata_d = (req_we || req_err) ? '0 : rd_word;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                    rdata_d = (we_q || err_q) ? '0 : rd_word;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs. req_ready is forced low while reset is held.
    always_comb begin
        req_ready = (state_q == IDLE) && !reset;
        rsp_valid = (state_q == RESP);
        rsp_rdata = rdata_q;
        rsp_err   = (state_q == RESP) && err_q;
    end

    // The down-counter is four bits wide, so only 1..15 is meaningful.
    always @(posedge clk) begin
        assert (LATENCY >= 1 && LATENCY <= 15)
            else $error("cpu_mem_responder: LATENCY=%0d outside 1..15", LATENCY);
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_cpu_mem_responder
//   Three responders with LATENCY 2, 1 and 15 run side by side. A timestamp
//   based reference model predicts req_ready / rsp_valid / rsp_rdata / rsp_err
//   every cycle, and directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_cpu_mem_responder;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst       [N];
    logic        req_valid [N];
    logic        req_ready [N];
    logic        req_we    [N];
    logic [18:0] req_addr  [N];
    logic [18:0] req_wdata [N];
    logic        rsp_valid [N];
    logic        rsp_ready [N];
    logic [18:0] rsp_rdata [N];
    logic        rsp_err   [N];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        cpu_mem_responder #(
            .DATA_W (19),
            .ADDR_W (19),
            .DEPTH  (1024),
            .LATENCY((g == 0) ? 2 : ((g == 1) ? 1 : 15))
        ) u_dut (
            .clk      (clk),
            .reset    (rst[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_we   (req_we[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err  (rsp_err[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bounded wait expired (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    // Each instance is either free or owns one outstanding request that was
    // accepted at edge acc; its response is visible from edge acc+L-1 onward.
    bit          m_busy [N];
    int          m_due  [N];
    bit          m_err  [N];
    bit          m_chk  [N];
    logic [18:0] m_rdata[N];
    logic [18:0] m_mem  [N][1024];
    bit          m_wr   [N][1024];

    initial begin
        int idx;
        bit exp_valid;
        for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (rst[i]) begin
                    m_busy[i] = 1'b0;
                end else if (!m_busy[i]) begin
                    if (req_valid[i]) begin
                        m_busy[i] = 1'b1;
                        m_due[i]  = cyc + lat_of(i) - 1;
                        m_err[i]  = (int'(req_addr[i]) >= 1024);
                        idx       = int'(req_addr[i]) % 1024;
                        if (req_we[i]) begin
                            if (!m_err[i]) begin
                                m_mem[i][idx] = req_wdata[i];
                                m_wr[i][idx]  = 1'b1;
                            end
                            m_rdata[i] = '0;
                            m_chk[i]   = 1'b1;
                        end else if (m_err[i]) begin
                            m_rdata[i] = '0;
                            m_chk[i]   = 1'b1;
                        end else begin
                            m_rdata[i] = m_mem[i][idx];
                            m_chk[i]   = m_wr[i][idx];
                        end
                    end
                end else if (cyc > m_due[i] && rsp_ready[i]) begin
                    m_busy[i] = 1'b0;
                end
            end

            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                exp_valid = !rst[i] && m_busy[i] && (cyc >= m_due[i]);
                check($sformatf("u%0d req_ready", i), 32'(req_ready[i]),
                      32'(!rst[i] && !m_busy[i]));
                check($sformatf("u%0d rsp_valid", i), 32'(rsp_valid[i]), 32'(exp_valid));
                if (exp_valid) begin
                    check($sformatf("u%0d rsp_err", i), 32'(rsp_err[i]), 32'(m_err[i]));
                    if (m_chk[i])
                        check($sformatf("u%0d rsp_rdata", i), 32'(rsp_rdata[i]), 32'(m_rdata[i]));
                end else if (rst[i]) begin
                    check($sformatf("u%0d rdata in reset", i), 32'(rsp_rdata[i]), 32'd0);
                    check($sformatf("u%0d err in reset", i), 32'(rsp_err[i]), 32'd0);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_req(input int i, input bit we, input logic [18:0] addr,
                          input logic [18:0] wd, input int hold,
                          output logic [18:0] rd, output bit er, output int lat);
        bit acc;
        bit got;
        int n;
        rd  = '0;
        er  = 1'b0;
        lat = 0;
        @(posedge clk); #1;
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = wd;
        rsp_ready[i] = 1'b0;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = req_ready[i];
            n++;
        end
        if (!acc) begin
            fail_timeout($sformatf("u%0d accept", i));
            req_valid[i] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        // Scramble the fields after acceptance; they must have no effect.
        req_valid[i] = 1'b0;
        req_we[i]    = 1'($urandom_range(0, 1));
        req_addr[i]  = 19'($urandom);
        req_wdata[i] = 19'($urandom);
        got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid[i]) begin
                got = 1'b1;
                lat = k;
            end
        end
        if (!got) begin
            fail_timeout($sformatf("u%0d rsp_valid", i));
            return;
        end
        rd = rsp_rdata[i];
        er = rsp_err[i];
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold rsp_valid", 32'(rsp_valid[i]), 32'd1);
            check("hold rsp_rdata stable", 32'(rsp_rdata[i]), 32'(rd));
            check("hold req_ready", 32'(req_ready[i]), 32'd0);
        end
        rsp_ready[i] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[i] = 1'b0;
        @(negedge clk);
        check("post-handshake rsp_valid", 32'(rsp_valid[i]), 32'd0);
        check("post-handshake req_ready", 32'(req_ready[i]), 32'd1);
    endtask

    // Hold req_valid high with rsp_ready high; acceptances must be L+1 apart.
    task automatic stream(input int i, input int n);
        int prev;
        int count;
        int guard;
        int acc_edge;
        @(posedge clk); #1;
        req_valid[i] = 1'b1;
        req_we[i]    = 1'b0;
        req_addr[i]  = 19'd3;
        rsp_ready[i] = 1'b1;
        prev  = -1;
        count = 0;
        guard = 0;
        while (count < n && guard < 200) begin
            @(negedge clk);
            guard++;
            if (req_ready[i]) begin
                acc_edge = cyc + 1;
                if (prev >= 0)
                    check($sformatf("u%0d acceptance spacing", i), 32'(acc_edge - prev),
                          32'(lat_of(i) + 1));
                prev = acc_edge;
                count++;
            end
        end
        if (count < n) fail_timeout($sformatf("u%0d stream", i));
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        repeat (lat_of(i) + 3) @(posedge clk);
        #1 rsp_ready[i] = 1'b0;
    endtask

    task automatic rand_run(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            rst[i]       = ($urandom_range(0, 149) == 0);
            req_valid[i] = 1'($urandom_range(0, 1));
            req_we[i]    = 1'($urandom_range(0, 1));
            req_addr[i]  = ($urandom_range(0, 7) == 0) ? 19'($urandom_range(1024, 524287))
                                                        : 19'($urandom_range(0, 15));
            req_wdata[i] = 19'($urandom);
            rsp_ready[i] = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        rst[i]       = 1'b0;
        req_valid[i] = 1'b0;
        rsp_ready[i] = 1'b1;
        repeat (20) @(posedge clk);
        #1 rsp_ready[i] = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [18:0] rd;
        bit          er;
        int          lat;
        int          n;

        for (int i = 0; i < N; i++) begin
            rst[i]       = 1'b1;
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            rsp_ready[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", 32'(req_ready[0]), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) rst[i] = 1'b0;
        @(negedge clk);
        check("first cycle after reset req_ready", 32'(req_ready[0]), 32'd1);

        // Write then read, then backpressure on the read.
        do_req(0, 1'b1, 19'h00005, 19'h7ABCD, 0, rd, er, lat);
        check("write latency", 32'(lat), 32'd2);
        check("write rdata", 32'(rd), 32'd0);
        check("write err", 32'(er), 32'd0);
        do_req(0, 1'b0, 19'h00005, 19'h0, 4, rd, er, lat);
        check("read latency", 32'(lat), 32'd2);
        check("read rdata", 32'(rd), 32'h7ABCD);
        check("read err", 32'(er), 32'd0);

        // Out of range write must not alias onto address 0.
        do_req(0, 1'b1, 19'h00000, 19'h00011, 0, rd, er, lat);
        do_req(0, 1'b1, 19'd1024, 19'h12345, 0, rd, er, lat);
        check("oob write err", 32'(er), 32'd1);
        check("oob write rdata", 32'(rd), 32'd0);
        do_req(0, 1'b0, 19'h00000, 19'h0, 0, rd, er, lat);
        check("addr 0 after oob write", 32'(rd), 32'h00011);
        do_req(0, 1'b0, 19'h7FFFF, 19'h0, 0, rd, er, lat);
        check("oob read err", 32'(er), 32'd1);
        check("oob read rdata", 32'(rd), 32'd0);

        // Busy ignore: a second request shown while busy is not taken.
        do_req(0, 1'b1, 19'd9, 19'h05555, 0, rd, er, lat);
        @(posedge clk); #1;
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 19'd5; rsp_ready[0] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[0] && n < 50);
        @(posedge clk); #1;
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 19'd9; req_wdata[0] = 19'h1;
        repeat (4) begin
            @(negedge clk);
            check("busy req_ready", 32'(req_ready[0]), 32'd0);
        end
        check("busy original rsp_valid", 32'(rsp_valid[0]), 32'd1);
        check("busy original rdata", 32'(rsp_rdata[0]), 32'h7ABCD);
        @(posedge clk); #1;
        req_valid[0] = 1'b0; rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        do_req(0, 1'b0, 19'd9, 19'h0, 0, rd, er, lat);
        check("mem[9] unchanged", 32'(rd), 32'h05555);

        // Reset while waiting: response discarded, write kept.
        @(posedge clk); #1;
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 19'd7; req_wdata[0] = 19'h00042;
        rsp_ready[0] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[0] && n < 50);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        rst[0]       = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("mid-op reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
            check("mid-op reset req_ready", 32'(req_ready[0]), 32'd0);
            check("mid-op reset rdata", 32'(rsp_rdata[0]), 32'd0);
        end
        @(posedge clk); #1;
        rst[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("after reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
            check("after reset req_ready", 32'(req_ready[0]), 32'd1);
        end
        do_req(0, 1'b0, 19'd7, 19'h0, 0, rd, er, lat);
        check("write survives reset", 32'(rd), 32'h00042);

        // Latency sweep on the LATENCY=1 and LATENCY=15 instances.
        do_req(1, 1'b1, 19'd3, 19'h13579, 0, rd, er, lat);
        do_req(1, 1'b0, 19'd3, 19'h0, 2, rd, er, lat);
        check("lat1 read latency", 32'(lat), 32'd1);
        check("lat1 read rdata", 32'(rd), 32'h13579);
        do_req(2, 1'b1, 19'd3, 19'h2468A, 0, rd, er, lat);
        do_req(2, 1'b0, 19'd3, 19'h0, 1, rd, er, lat);
        check("lat15 read latency", 32'(lat), 32'd15);
        check("lat15 read rdata", 32'(rd), 32'h2468A);
        stream(1, 5);
        stream(2, 3);

        // Randomised traffic on all instances at once.
        fork
            rand_run(0, 600);
            rand_run(1, 600);
            rand_run(2, 600);
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder serving the 19-bit CPU's load/store traffic.
- Accepts one request at a time over a valid/ready request channel.
- Models a fixed access latency and returns read data or write completion over a valid/ready response channel.
- Flags out-of-range addresses with an error bit.

Parameters:
- DATA_W, 19, data word width (matches CPU datapath)
- ADDR_W, 19, request address width
- DEPTH, 1024, number of implemented words; valid addresses are 0..DEPTH-1
- LATENCY, 2, cycles from request acceptance edge to rsp_valid high; legal range 1..15

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  word address
- req_wdata  input  DATA_W  write data
- rsp_valid  output  1  response present
- rsp_ready  input  1  CPU accepts the response
- rsp_rdata  output  DATA_W  read data; 0 for writes and errors
- rsp_err  output  1  address >= DEPTH

Behaviour:
- Reset (async, active-high):
  - state=IDLE; req_ready=0 while reset is asserted, 1 in the first cycle after deassertion.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
  - Memory array contents are NOT cleared and are retained across reset.
- FSM states IDLE, WAIT, RESP:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/wdata and compute err=(addr>=DEPTH). If LATENCY==1 go to RESP, else go to WAIT with counter=LATENCY-1.
  - WAIT: req_ready=0. Decrement the counter each cycle; go to RESP when the counter reaches 1.
  - RESP: req_ready=0, rsp_valid=1. Hold rsp_rdata/rsp_err stable until rsp_ready is sampled high, then go to IDLE with rsp_valid=0 next cycle.
- Write commit: the array write occurs on the acceptance edge, only if err=0. Out-of-range writes are dropped.
- Read capture: read data is captured from the array on the edge entering RESP. rsp_rdata=mem[addr] if err=0, else 0. Writes return rsp_rdata=0.
- Latency: rsp_valid rises exactly LATENCY cycles after the acceptance edge, independent of rsp_ready.
- No back-to-back acceptance: at least one IDLE cycle always separates a response handshake from the next request acceptance. Maximum throughput is 1 request per LATENCY+1 cycles.
- rsp_ready high outside RESP has no effect. req_valid while busy is ignored; the request must be held by the initiator.
- Request fields are sampled only at acceptance; changes afterwards have no effect.
- Address compare uses full ADDR_W bits. The array index is the low ceil(log2(DEPTH)) bits, used only when err=0.
- Reset mid-operation (WAIT or RESP): abort immediately to IDLE and discard the response. A write accepted before reset stays committed.
- Simulation assertion: flag LATENCY outside 1..15.

Test Plan:
- Write then read: write addr 0x00005 data 0x7ABCD, rsp_ready=1 -> write rsp_valid 2 cycles after acceptance, rdata=0, err=0; read addr 5 -> rsp_rdata=0x7ABCD, err=0.
- Backpressure: read addr 5 with rsp_ready=0 for 4 cycles -> rsp_valid held high, rdata=0x7ABCD stable, req_ready=0 throughout; rsp_ready=1 -> rsp_valid=0 next cycle, req_ready=1.
- Out of range: write addr 1024 data 0x12345 -> err=1, rdata=0; then read addr 0 (previously written 0x00011) -> 0x00011, confirming no aliasing of the dropped write.
- Latency sweep: LATENCY=1 and LATENCY=15, read addr 3 -> rsp_valid exactly 1 and 15 cycles after the acceptance edge; req_valid held continuously -> next acceptance no sooner than 1 cycle after the response handshake.
- Reset mid-operation: accept write addr 7 data 0x00042, assert reset in WAIT -> rsp_valid never rises, outputs 0. After reset, read addr 7 -> 0x00042.
- Busy ignore: while in WAIT, drive a different request (addr 9, write 0x1) -> not accepted, mem[9] unchanged, and the original response is returned.
